game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Frame-rate game controller for the ball/paddle VGA game. Samples ball and paddle
//  bounding boxes once per frame (animate strobe) and sequences IDLE/PLAY/MISS/OVER.
//  Counts paddle hits (score) and misses (lives). Drives hold/reload controls to the
//  ball animator. Sits beside the ball and paddle instances in the top level.
// PARAMETERS
//  LIVES        3    lives loaded at reset and at restart from OVER (1..3)
//  SCREEN_H     480  ball y2 >= SCREEN_H counts as a miss
//  MISS_FRAMES  60   frames spent in MISS before returning to IDLE (1..255)
//  SCORE_MAX    255  score saturates at this value
// PORTS
//  i_clk        in   1   system clock
//  i_rst_n      in   1   synchronous reset, active-low
//  i_animate    in   1   one-cycle pulse at end of frame; all game events evaluate here only
//  i_btn_serve  in   1   serve button level, synchronous; rising edge detected internally
//  i_ball_x1    in   12  ball left edge
//  i_ball_x2    in   12  ball right edge
//  i_ball_y1    in   12  ball top edge
//  i_ball_y2    in   12  ball bottom edge
//  i_pad_x1     in   12  paddle left edge
//  i_pad_x2     in   12  paddle right edge
//  i_pad_y1     in   12  paddle top edge
//  o_ball_hold  out  1   1 = ball animator freezes position
//  o_ball_reload out 1   1 = ball animator loads its initial position
//  o_state      out  2   0 IDLE, 1 PLAY, 2 MISS, 3 OVER
//  o_score      out  8   paddle hits, saturating
//  o_lives      out  2   lives remaining
//  o_game_over  out  1   1 while in OVER
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-low. All outputs registered.
//  Reset (i_rst_n=0 at posedge, any state incl. mid-game): state=IDLE, score=0,
//   lives=LIVES, miss_cnt=0, hit_armed=1, serve edge reg=0; hold=1, reload=1, game_over=0.
//  Serve edge: serve_pe = i_btn_serve & ~btn_q; btn_q registered every cycle.
//   Evaluated on any cycle (not gated by i_animate); held level does not retrigger.
//  contact = (i_ball_y2 >= i_pad_y1) & (i_ball_y1 < i_pad_y1)
//            & (i_ball_x2 > i_pad_x1) & (i_ball_x1 < i_pad_x2); unsigned 12-bit compares.
//  miss    = i_ball_y2 >= SCREEN_H.
//  IDLE: hold=1, reload=1. serve_pe -> PLAY, hit_armed=1.
//  PLAY: hold=0, reload=0. On i_animate only, priority miss > hit:
//   miss & lives>1  -> lives-1, miss_cnt=MISS_FRAMES, -> MISS.
//   miss & lives==1 -> lives=0, -> OVER.
//   else contact & hit_armed -> score+1 (hold at SCORE_MAX), hit_armed=0.
//   else ~contact -> hit_armed=1 (one point per paddle contact, no multi-count).
//   serve_pe ignored.
//  MISS: hold=1, reload=1. Each i_animate: miss_cnt-1; on the pulse where miss_cnt==1
//   -> IDLE (exactly MISS_FRAMES animate pulses spent in MISS). serve_pe ignored.
//  OVER: hold=1, reload=1, game_over=1. serve_pe -> score=0, lives=LIVES,
//   hit_armed=1, -> PLAY (restart without IDLE).
//  Outputs o_hold/o_reload/o_game_over/o_state change the cycle after the transition edge
//   (registered from next state); score/lives update 1 cycle after the i_animate pulse.
//  i_animate and serve_pe in same cycle in IDLE/OVER: serve transition taken; animate
//   has no effect there.
// TESTING
//  1 reset, no serve, 10 animate pulses -> state=0, hold=1, reload=1, lives=3, score=0.
//  2 serve pulse; ball contacts paddle for 5 consecutive frames then leaves, repeat 3x
//    -> score=3 (not 15), state=1, hold=0.
//  3 PLAY, ball_y2=480 on one frame -> lives=2, state=2; after 60 animate pulses state=0;
//    serve pressed during MISS ignored.
//  4 three misses -> lives=0, state=3, game_over=1; serve -> state=1, lives=3, score=0.
//  5 same frame miss and contact -> lives decremented, score unchanged.
//  6 score forced to 254, two hits -> 255, 255; assert i_rst_n=0 in MISS -> IDLE defaults.

Source files
------------

// File: rtl/game_sequencer.sv
// Frame-rate game controller for the ball/paddle game.
// Samples ball and paddle boxes on each animate strobe and sequences
// IDLE -> PLAY -> MISS/OVER, tracking score (paddle hits) and lives (misses).
// o_state exposes the FSM state directly for observation.
// There is no valid/ready handshake here: i_animate is a single-cycle strobe
// that is acted on in the cycle it is high, and the serve button is a level
// whose rising edge is detected internally on every cycle.
module game_sequencer #(
  parameter int LIVES       = 3,
  parameter int SCREEN_H    = 480,
  parameter int MISS_FRAMES = 60,
  parameter int SCORE_MAX   = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_animate,
  input  logic        i_btn_serve,
  input  logic [11:0] i_ball_x1,
  input  logic [11:0] i_ball_x2,
  input  logic [11:0] i_ball_y1,
  input  logic [11:0] i_ball_y2,
  input  logic [11:0] i_pad_x1,
  input  logic [11:0] i_pad_x2,
  input  logic [11:0] i_pad_y1,
  output logic        o_ball_hold,
  output logic        o_ball_reload,
  output logic [1:0]  o_state,
  output logic [7:0]  o_score,
  output logic [1:0]  o_lives,
  output logic        o_game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_MISS = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
  localparam logic [7:0]  MISS_INIT  = 8'(MISS_FRAMES);
  localparam logic [7:0]  SCORE_SAT  = 8'(SCORE_MAX);
  localparam logic [11:0] SCREEN_Y   = 12'(SCREEN_H);

  state_t      r_state, w_state_nx;
  logic [7:0]  r_score, w_score_nx;
  logic [1:0]  r_lives, w_lives_nx;
  logic [7:0]  r_miss_cnt, w_miss_cnt_nx;
  logic        r_hit_armed, w_hit_armed_nx;
  logic        r_btn_q;
  logic        r_hold, r_reload, r_game_over;
  logic        w_serve_pe, w_contact, w_miss;

  assign w_serve_pe = i_btn_serve & ~r_btn_q;
  assign w_contact  = (i_ball_y2 >= i_pad_y1) & (i_ball_y1 < i_pad_y1)
                    & (i_ball_x2 > i_pad_x1) & (i_ball_x1 < i_pad_x2);
  assign w_miss     = (i_ball_y2 >= SCREEN_Y);

  // Next-state and next-counter logic; everything defaults to holding its value.
  always_comb begin
    w_state_nx     = r_state;
    w_score_nx     = r_score;
    w_lives_nx     = r_lives;
    w_miss_cnt_nx  = r_miss_cnt;
    w_hit_armed_nx = r_hit_armed;
    case (r_state)
      S_IDLE: begin
        if (w_serve_pe) begin
          w_state_nx     = S_PLAY;
          w_hit_armed_nx = 1'b1;
        end
      end
      S_PLAY: begin
        if (i_animate) begin
          // A miss outranks a simultaneous paddle contact.
          if (w_miss) begin
            if (r_lives > 2'd1) begin
              w_lives_nx    = r_lives - 2'd1;
              w_miss_cnt_nx = MISS_INIT;
              w_state_nx    = S_MISS;
            end else begin
              w_lives_nx = 2'd0;
              w_state_nx = S_OVER;
            end
          end else if (w_contact && r_hit_armed) begin
            if (r_score < SCORE_SAT) w_score_nx = r_score + 8'd1;
            w_hit_armed_nx = 1'b0;
          end else if (!w_contact) begin
            // Re-arm only once the ball has left the paddle.
            w_hit_armed_nx = 1'b1;
          end
        end
      end
      S_MISS: begin
        if (i_animate) begin
          w_miss_cnt_nx = r_miss_cnt - 8'd1;
          if (r_miss_cnt == 8'd1) w_state_nx = S_IDLE;
        end
      end
      S_OVER: begin
        if (w_serve_pe) begin
          w_score_nx     = 8'd0;
          w_lives_nx     = LIVES_INIT;
          w_hit_armed_nx = 1'b1;
          w_state_nx     = S_PLAY;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State, counters and registered controls; controls follow the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_score     <= 8'd0;
      r_lives     <= LIVES_INIT;
      r_miss_cnt  <= 8'd0;
      r_hit_armed <= 1'b1;
      r_btn_q     <= 1'b0;
      r_hold      <= 1'b1;
      r_reload    <= 1'b1;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_score     <= w_score_nx;
      r_lives     <= w_lives_nx;
      r_miss_cnt  <= w_miss_cnt_nx;
      r_hit_armed <= w_hit_armed_nx;
      r_btn_q     <= i_btn_serve;
      r_hold      <= (w_state_nx != S_PLAY);
      r_reload    <= (w_state_nx != S_PLAY);
      r_game_over <= (w_state_nx == S_OVER);
    end
  end

  assign o_state       = r_state;
  assign o_score       = r_score;
  assign o_lives       = r_lives;
  assign o_ball_hold   = r_hold;
  assign o_ball_reload = r_reload;
  assign o_game_over   = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a vector table of per-cycle stimulus with expected
// status, then hand-written sequences for saturation and mid-game reset.
module tb_game_sequencer;

  localparam logic [1:0] B_AWAY = 2'd0, B_HIT = 2'd1, B_MISS = 2'd2, B_BOTH = 2'd3;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_MISS = 2'd2, ST_OVER = 2'd3;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_animate = 1'b0;
  logic        i_btn_serve = 1'b0;
  logic [11:0] i_ball_x1, i_ball_x2, i_ball_y1, i_ball_y2;
  logic [11:0] i_pad_x1 = 12'd280, i_pad_x2 = 12'd360, i_pad_y1 = 12'd440;
  logic        o_ball_hold, o_ball_reload, o_game_over;
  logic [1:0]  o_state, o_lives;
  logic [7:0]  o_score;

  game_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_animate(i_animate), .i_btn_serve(i_btn_serve),
    .i_ball_x1(i_ball_x1), .i_ball_x2(i_ball_x2), .i_ball_y1(i_ball_y1), .i_ball_y2(i_ball_y2),
    .i_pad_x1(i_pad_x1), .i_pad_x2(i_pad_x2), .i_pad_y1(i_pad_y1),
    .o_ball_hold(o_ball_hold), .o_ball_reload(o_ball_reload), .o_state(o_state),
    .o_score(o_score), .o_lives(o_lives), .o_game_over(o_game_over)
  );

  // Clock and reset
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       serve;
    logic       anim;
    logic [1:0] ball;
    logic [1:0] st;
    logic [7:0] sc;
    logic [1:0] lv;
  } vec_t;

  vec_t        vecs[512];
  int          n_vec = 0;
  logic [14:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Status word: {state, score, lives, hold, reload, game_over}; controls derived from state.
  function automatic logic [14:0] pack(input logic [1:0] st, input logic [7:0] sc,
                                       input logic [1:0] lv);
    logic ctl;
    ctl = (st != ST_PLAY);
    return {st, sc, lv, ctl, ctl, (st == ST_OVER)};
  endfunction

  function automatic void add(input logic sv, input logic an, input logic [1:0] b,
                              input logic [1:0] st, input logic [7:0] sc, input logic [1:0] lv);
    vecs[n_vec] = '{sv, an, b, st, sc, lv};
    n_vec++;
  endfunction

  // Driver tasks
  task automatic set_ball(input logic [1:0] sel);
    i_ball_x1 = 12'd300;
    i_ball_x2 = 12'd310;
    case (sel)
      B_AWAY:  begin i_ball_y1 = 12'd100; i_ball_y2 = 12'd110; end
      B_HIT:   begin i_ball_y1 = 12'd435; i_ball_y2 = 12'd445; end
      B_MISS:  begin i_ball_y1 = 12'd470; i_ball_y2 = 12'd480; end
      default: begin i_ball_y1 = 12'd430; i_ball_y2 = 12'd480; end
    endcase
  endtask

  task automatic cycle(input logic sv, input logic an, input logic [1:0] b);
    i_btn_serve = sv;
    i_animate   = an;
    set_ball(b);
    @(posedge i_clk);
    #1;
    i_animate = 1'b0;
  endtask

  // Scoreboard: expectation queued with the stimulus, popped against the DUT.
  task automatic check(input string name, input logic [14:0] exp);
    logic [14:0] got, e;
    exp_q.push_back(exp);
    got = {o_state, o_score, o_lives, o_ball_hold, o_ball_reload, o_game_over};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got st=%0d sc=%0d lv=%0d h/r/go=%b required st=%0d sc=%0d lv=%0d h/r/go=%b",
               name, got[14:13], got[12:5], got[4:3], got[2:0],
               e[14:13], e[12:5], e[4:3], e[2:0]);
    end
  endtask

  task automatic add_miss_wait(input logic [7:0] sc, input logic [1:0] lv);
    for (int i = 1; i < 60; i++) add(1'b0, 1'b1, B_AWAY, ST_MISS, sc, lv);
    add(1'b0, 1'b1, B_AWAY, ST_IDLE, sc, lv);
  endtask

  initial begin
    // Test 1: no serve, animate pulses leave IDLE untouched.
    for (int i = 0; i < 10; i++) add(1'b0, 1'b1, B_AWAY, ST_IDLE, 8'd0, 2'd3);
    // Test 2: serve, then three paddle contacts of five frames each.
    add(1'b1, 1'b0, B_AWAY, ST_PLAY, 8'd0, 2'd3);
    add(1'b0, 1'b0, B_AWAY, ST_PLAY, 8'd0, 2'd3);
    for (int r = 0; r < 3; r++) begin
      for (int f = 0; f < 5; f++) add(1'b0, 1'b1, B_HIT, ST_PLAY, 8'(r + 1), 2'd3);
      add(1'b0, 1'b1, B_AWAY, ST_PLAY, 8'(r + 1), 2'd3);
    end
    // Test 5: miss and contact in the same frame; the miss wins.
    add(1'b0, 1'b1, B_BOTH, ST_MISS, 8'd3, 2'd2);
    // Serve pressed during MISS is ignored, then 60 frames back to IDLE.
    add(1'b1, 1'b0, B_AWAY, ST_MISS, 8'd3, 2'd2);
    add(1'b0, 1'b0, B_AWAY, ST_MISS, 8'd3, 2'd2);
    add_miss_wait(8'd3, 2'd2);
    // Test 3: second miss from a fresh serve.
    add(1'b1, 1'b0, B_AWAY, ST_PLAY, 8'd3, 2'd2);
    add(1'b0, 1'b1, B_MISS, ST_MISS, 8'd3, 2'd1);
    add(1'b1, 1'b1, B_AWAY, ST_MISS, 8'd3, 2'd1);
    add(1'b1, 1'b0, B_AWAY, ST_MISS, 8'd3, 2'd1);
    add(1'b0, 1'b0, B_AWAY, ST_MISS, 8'd3, 2'd1);
    for (int i = 2; i < 60; i++) add(1'b0, 1'b1, B_AWAY, ST_MISS, 8'd3, 2'd1);
    add(1'b0, 1'b1, B_AWAY, ST_IDLE, 8'd3, 2'd1);
    // Test 4: last life lost -> OVER; held serve level does not retrigger.
    add(1'b1, 1'b0, B_AWAY, ST_PLAY, 8'd3, 2'd1);
    add(1'b1, 1'b1, B_MISS, ST_OVER, 8'd3, 2'd0);
    add(1'b1, 1'b1, B_AWAY, ST_OVER, 8'd3, 2'd0);
    add(1'b0, 1'b1, B_AWAY, ST_OVER, 8'd3, 2'd0);
    // Serve and animate in the same cycle in OVER: restart straight to PLAY.
    add(1'b1, 1'b1, B_AWAY, ST_PLAY, 8'd0, 2'd3);
    add(1'b0, 1'b0, B_AWAY, ST_PLAY, 8'd0, 2'd3);

    set_ball(B_AWAY);
    repeat (2) @(posedge i_clk);
    #1;
    check("reset", pack(ST_IDLE, 8'd0, 2'd3));
    i_rst_n = 1'b1;

    for (int v = 0; v < n_vec; v++) begin
      cycle(vecs[v].serve, vecs[v].anim, vecs[v].ball);
      check($sformatf("vec%0d", v), pack(vecs[v].st, vecs[v].sc, vecs[v].lv));
    end

    // Test 6: drive score to 254, then two more hits saturate at 255.
    for (int i = 0; i < 254; i++) begin
      cycle(1'b0, 1'b1, B_HIT);
      cycle(1'b0, 1'b1, B_AWAY);
    end
    check("score_254", pack(ST_PLAY, 8'd254, 2'd3));
    cycle(1'b0, 1'b1, B_HIT);
    check("score_255", pack(ST_PLAY, 8'd255, 2'd3));
    cycle(1'b0, 1'b1, B_AWAY);
    cycle(1'b0, 1'b1, B_HIT);
    check("score_sat", pack(ST_PLAY, 8'd255, 2'd3));
    cycle(1'b0, 1'b1, B_MISS);
    check("sat_miss", pack(ST_MISS, 8'd255, 2'd2));
    repeat (3) cycle(1'b0, 1'b1, B_AWAY);
    check("in_miss", pack(ST_MISS, 8'd255, 2'd2));
    // Reset asserted mid-MISS returns every output to its idle default.
    i_rst_n = 1'b0;
    cycle(1'b0, 1'b1, B_AWAY);
    check("reset_mid", pack(ST_IDLE, 8'd0, 2'd3));
    i_rst_n = 1'b1;
    cycle(1'b0, 1'b1, B_AWAY);
    check("post_reset", pack(ST_IDLE, 8'd0, 2'd3));
    cycle(1'b1, 1'b0, B_AWAY);
    check("post_serve", pack(ST_PLAY, 8'd0, 2'd3));
    cycle(1'b0, 1'b1, B_HIT);
    check("post_hit", pack(ST_PLAY, 8'd1, 2'd3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
